// File: rtl/pacman_pkg.sv
// Shared constants for the maze game datapath: sprite indices, direction
// encodings, coordinate widths and sprite home positions.
package pacman_pkg;

  localparam int unsigned X_W         = 11;
  localparam int unsigned Y_W         = 10;
  localparam int unsigned DIR_W       = 4;
  localparam int unsigned SPRITE_W    = 3;
  localparam int unsigned NUM_SPRITES = 5;

  localparam int unsigned PACMAN = 0;
  localparam int unsigned BLINKY = 1;
  localparam int unsigned PINKY  = 2;
  localparam int unsigned INKY   = 3;
  localparam int unsigned CLYDE  = 4;

  localparam logic [DIR_W-1:0] RIGHT = 4'b0001;
  localparam logic [DIR_W-1:0] UP    = 4'b0010;
  localparam logic [DIR_W-1:0] DOWN  = 4'b0100;
  localparam logic [DIR_W-1:0] LEFT  = 4'b1000;

  localparam int unsigned RST_PACMAN_X = 1367;
  localparam int unsigned RST_PACMAN_Y = 306;
  localparam int unsigned RST_BLINKY_X = 1399;
  localparam int unsigned RST_BLINKY_Y = 130;
  localparam int unsigned RST_PINKY_X  = 439;
  localparam int unsigned RST_PINKY_Y  = 434;
  localparam int unsigned RST_INKY_X   = 1031;
  localparam int unsigned RST_INKY_Y   = 402;
  localparam int unsigned RST_CLYDE_X  = 1415;
  localparam int unsigned RST_CLYDE_Y  = 66;

endpackage

// File: rtl/ghost_tick_divider.sv
// Counts accepted game ticks and flags the ticks on which the ghosts move.
module ghost_tick_divider #(
  parameter int unsigned GHOST_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic ghost_go_c
);

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] cnt_q;

  assign ghost_go_c = (cnt_q == CNT_W'(GHOST_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= ghost_go_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sprite_move_scheduler.sv
// Shares one position-update unit across all sprites: snapshots directions on
// a game tick, issues sprites in order and keeps the authoritative positions.
module sprite_move_scheduler
  import pacman_pkg::*;
#(
  parameter int unsigned UPD_LATENCY  = 1,
  parameter int unsigned GHOST_PERIOD = 2,
  parameter int unsigned PACMAN_RST_X = RST_PACMAN_X,
  parameter int unsigned PACMAN_RST_Y = RST_PACMAN_Y,
  parameter int unsigned BLINKY_RST_X = RST_BLINKY_X,
  parameter int unsigned BLINKY_RST_Y = RST_BLINKY_Y,
  parameter int unsigned PINKY_RST_X  = RST_PINKY_X,
  parameter int unsigned PINKY_RST_Y  = RST_PINKY_Y,
  parameter int unsigned INKY_RST_X   = RST_INKY_X,
  parameter int unsigned INKY_RST_Y   = RST_INKY_Y,
  parameter int unsigned CLYDE_RST_X  = RST_CLYDE_X,
  parameter int unsigned CLYDE_RST_Y  = RST_CLYDE_Y
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 game_tick,
  input  logic [DIR_W-1:0]                     pacman_dir,
  input  logic [DIR_W*(NUM_SPRITES-1)-1:0]     ghost_dir,
  output logic [X_W-1:0]                       upd_cur_x,
  output logic [Y_W-1:0]                       upd_cur_y,
  output logic [DIR_W-1:0]                     upd_dir,
  output logic [SPRITE_W-1:0]                  upd_sprite,
  input  logic [X_W-1:0]                       upd_new_x,
  input  logic [Y_W-1:0]                       upd_new_y,
  output logic [X_W*NUM_SPRITES-1:0]           pos_x,
  output logic [Y_W*NUM_SPRITES-1:0]           pos_y,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic                                 tick_overrun
);

  localparam int unsigned LAT_W   = 3;
  localparam int unsigned GDIR_W  = DIR_W * (NUM_SPRITES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [SPRITE_W-1:0] slot_q, slot_d;
  logic [LAT_W-1:0]    wait_q, wait_d;
  logic                go_q, go_d;
  logic [DIR_W-1:0]    pac_dir_q, pac_dir_d;
  logic [GDIR_W-1:0]   ghost_dir_q, ghost_dir_d;
  logic                tick_accept_c;
  logic                capture_c;
  logic                ghost_go_c;
  logic [DIR_W-1:0]    issue_dir_c;

  logic [X_W-1:0] pos_x_q [NUM_SPRITES];
  logic [Y_W-1:0] pos_y_q [NUM_SPRITES];

  ghost_tick_divider #(
    .GHOST_PERIOD (GHOST_PERIOD)
  ) u_ghost_div (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick_accept_c),
    .ghost_go_c (ghost_go_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, slot sequencing and direction snapshot.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    wait_d        = wait_q;
    go_d          = go_q;
    pac_dir_d     = pac_dir_q;
    ghost_dir_d   = ghost_dir_q;
    tick_accept_c = 1'b0;
    capture_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (game_tick) begin
          tick_accept_c = 1'b1;
          pac_dir_d     = pacman_dir;
          ghost_dir_d   = ghost_dir;
          go_d          = ghost_go_c;
          slot_d        = '0;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        wait_d  = LAT_W'(UPD_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        wait_d = wait_q - LAT_W'(1);
        if (wait_q == LAT_W'(1)) begin
          capture_c = 1'b1;
          if (go_q && (slot_q != SPRITE_W'(CLYDE))) begin
            slot_d  = slot_q + SPRITE_W'(1);
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Direction of the sprite about to be issued, taken from the (new) snapshot.
  always_comb begin
    issue_dir_c = pac_dir_d;
    case (slot_d)
      SPRITE_W'(BLINKY): issue_dir_c = ghost_dir_d[0*DIR_W +: DIR_W];
      SPRITE_W'(PINKY):  issue_dir_c = ghost_dir_d[1*DIR_W +: DIR_W];
      SPRITE_W'(INKY):   issue_dir_c = ghost_dir_d[2*DIR_W +: DIR_W];
      SPRITE_W'(CLYDE):  issue_dir_c = ghost_dir_d[3*DIR_W +: DIR_W];
      default:           issue_dir_c = pac_dir_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= '0;
      wait_q      <= '0;
      go_q        <= 1'b0;
      pac_dir_q   <= '0;
      ghost_dir_q <= '0;
    end else begin
      slot_q      <= slot_d;
      wait_q      <= wait_d;
      go_q        <= go_d;
      pac_dir_q   <= pac_dir_d;
      ghost_dir_q <= ghost_dir_d;
    end
  end

  // Position file, update-unit drive registers and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x_q[PACMAN] <= X_W'(PACMAN_RST_X);
      pos_y_q[PACMAN] <= Y_W'(PACMAN_RST_Y);
      pos_x_q[BLINKY] <= X_W'(BLINKY_RST_X);
      pos_y_q[BLINKY] <= Y_W'(BLINKY_RST_Y);
      pos_x_q[PINKY]  <= X_W'(PINKY_RST_X);
      pos_y_q[PINKY]  <= Y_W'(PINKY_RST_Y);
      pos_x_q[INKY]   <= X_W'(INKY_RST_X);
      pos_y_q[INKY]   <= Y_W'(INKY_RST_Y);
      pos_x_q[CLYDE]  <= X_W'(CLYDE_RST_X);
      pos_y_q[CLYDE]  <= Y_W'(CLYDE_RST_Y);
      upd_cur_x       <= '0;
      upd_cur_y       <= '0;
      upd_dir         <= '0;
      upd_sprite      <= '0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      tick_overrun    <= 1'b0;
    end else begin
      if (capture_c) begin
        pos_x_q[slot_q] <= upd_new_x;
        pos_y_q[slot_q] <= upd_new_y;
      end
      if (state_d == ISSUE) begin
        upd_sprite <= slot_d;
        upd_cur_x  <= pos_x_q[slot_d];
        upd_cur_y  <= pos_y_q[slot_d];
        upd_dir    <= issue_dir_c;
      end
      busy       <= (state_d != IDLE);
      frame_done <= (state_d == DONE);
      if (game_tick && (state_q != IDLE)) begin
        tick_overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SPRITES; s++) begin
      pos_x[s*X_W +: X_W] = pos_x_q[s];
      pos_y[s*Y_W +: Y_W] = pos_y_q[s];
    end
  end

endmodule

// File: tb/tb_sprite_move_scheduler.sv
// Bench for sprite_move_scheduler: frame-schedule reference model, directed
// scenarios with literal expectations, then randomized ticks and directions.
module tb_sprite_move_scheduler;

  localparam int LAT = 1;
  localparam int GP  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        game_tick;
  logic [3:0]  pacman_dir;
  logic [15:0] ghost_dir;
  logic [10:0] upd_cur_x;
  logic [9:0]  upd_cur_y;
  logic [3:0]  upd_dir;
  logic [2:0]  upd_sprite;
  logic [10:0] upd_new_x;
  logic [9:0]  upd_new_y;
  logic [54:0] pos_x;
  logic [49:0] pos_y;
  logic        busy;
  logic        frame_done;
  logic        tick_overrun;

  always #5 clk = ~clk;

  sprite_move_scheduler #(
    .UPD_LATENCY  (LAT),
    .GHOST_PERIOD (GP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .game_tick    (game_tick),
    .pacman_dir   (pacman_dir),
    .ghost_dir    (ghost_dir),
    .upd_cur_x    (upd_cur_x),
    .upd_cur_y    (upd_cur_y),
    .upd_dir      (upd_dir),
    .upd_sprite   (upd_sprite),
    .upd_new_x    (upd_new_x),
    .upd_new_y    (upd_new_y),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .busy         (busy),
    .frame_done   (frame_done),
    .tick_overrun (tick_overrun)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", nm, $time, got, exp);
    end
  endtask

  function automatic logic [10:0] mv_x(input logic [3:0] d, input logic [10:0] x);
    case (d)
      4'b0001: return x + 11'd15;
      4'b1000: return x - 11'd15;
      default: return x;
    endcase
  endfunction

  function automatic logic [9:0] mv_y(input logic [3:0] d, input logic [9:0] y);
    case (d)
      4'b0010: return y - 10'd15;
      4'b0100: return y + 10'd15;
      default: return y;
    endcase
  endfunction

  // Update unit: one register stage between the drive and the result.
  always @(posedge clk) begin
    upd_new_x <= mv_x(upd_dir, upd_cur_x);
    upd_new_y <= mv_y(upd_dir, upd_cur_y);
  end

  // Reference model: frame length and issue/capture cycles from slot arithmetic.
  logic [10:0] m_x [5];
  logic [9:0]  m_y [5];
  logic [3:0]  m_dir [5];
  int          m_fc, m_n, m_gcnt;
  logic        e_busy, e_fd, e_ovr;
  logic [2:0]  e_sprite;
  logic [10:0] e_cx;
  logic [9:0]  e_cy;
  logic [3:0]  e_dir;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_x[0] = 11'd1367; m_y[0] = 10'd306;
      m_x[1] = 11'd1399; m_y[1] = 10'd130;
      m_x[2] = 11'd439;  m_y[2] = 10'd434;
      m_x[3] = 11'd1031; m_y[3] = 10'd402;
      m_x[4] = 11'd1415; m_y[4] = 10'd66;
      m_fc = 0; m_n = 0; m_gcnt = 0;
      e_busy = 1'b0; e_fd = 1'b0; e_ovr = 1'b0;
      e_sprite = '0; e_cx = '0; e_cy = '0; e_dir = '0;
    end else begin
      if (m_fc == 0) begin
        if (game_tick) begin
          m_dir[0] = pacman_dir;
          for (int k = 1; k < 5; k++) m_dir[k] = ghost_dir[4*(k-1) +: 4];
          m_n    = (m_gcnt == GP - 1) ? 5 : 1;
          m_gcnt = (m_gcnt == GP - 1) ? 0 : m_gcnt + 1;
          m_fc   = 1;
        end
      end else begin
        if (game_tick) e_ovr = 1'b1;
        m_fc = (m_fc == m_n * (1 + LAT) + 1) ? 0 : m_fc + 1;
      end
      if (m_fc != 0) begin
        for (int k = 0; k < m_n; k++) begin
          int ic;
          ic = 1 + (1 + LAT) * k;
          if (m_fc == ic + LAT + 1) begin
            m_x[k] = mv_x(m_dir[k], m_x[k]);
            m_y[k] = mv_y(m_dir[k], m_y[k]);
          end
          if (m_fc == ic) begin
            e_sprite = 3'(k); e_cx = m_x[k]; e_cy = m_y[k]; e_dir = m_dir[k];
          end
        end
      end
      e_busy = (m_fc != 0);
      e_fd   = (m_fc != 0) && (m_fc == m_n * (1 + LAT) + 1);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(e_busy));
      chk("frame_done", 64'(frame_done), 64'(e_fd));
      chk("tick_overrun", 64'(tick_overrun), 64'(e_ovr));
      chk("upd_sprite", 64'(upd_sprite), 64'(e_sprite));
      chk("upd_cur_x", 64'(upd_cur_x), 64'(e_cx));
      chk("upd_cur_y", 64'(upd_cur_y), 64'(e_cy));
      chk("upd_dir", 64'(upd_dir), 64'(e_dir));
      for (int s = 0; s < 5; s++) begin
        chk($sformatf("pos_x%0d", s), 64'(pos_x[11*s +: 11]), 64'(m_x[s]));
        chk($sformatf("pos_y%0d", s), 64'(pos_y[10*s +: 10]), 64'(m_y[s]));
      end
    end
  end

  // Per-cycle observations of the most recent directed frame.
  logic [2:0]  cyc_sprite [32];
  logic [3:0]  cyc_dir    [32];
  logic        cyc_busy   [32];
  logic [10:0] cyc_px0    [32];
  logic [9:0]  cyc_by     [32];

  task automatic frame(input int budget, input int ovr_at, input int rst_at,
                       input logic [3:0] pd_at1, output int first_fd, output int n_fd);
    game_tick = 1'b1;
    @(negedge clk);
    game_tick = 1'b0;
    first_fd  = 0;
    n_fd      = 0;
    for (int c = 1; c <= budget; c++) begin
      cyc_sprite[c] = upd_sprite;
      cyc_dir[c]    = upd_dir;
      cyc_busy[c]   = busy;
      cyc_px0[c]    = pos_x[10:0];
      cyc_by[c]     = pos_y[19:10];
      if (frame_done) begin
        n_fd++;
        if (first_fd == 0) first_fd = c;
      end
      if (c == 1 && pd_at1 != 4'b0000) pacman_dir = pd_at1;
      game_tick = (c == ovr_at);
      rst       = (c == rst_at);
      @(negedge clk);
    end
    game_tick = 1'b0;
    rst       = 1'b0;
  endtask

  int fd1, nfd;

  initial begin
    rst = 1'b1; game_tick = 1'b0; pacman_dir = 4'b0000; ghost_dir = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst pacman x", 64'(pos_x[10:0]), 64'd1367);
    chk("rst pacman y", 64'(pos_y[9:0]), 64'd306);
    chk("rst clyde x", 64'(pos_x[54:44]), 64'd1415);
    chk("rst clyde y", 64'(pos_y[49:40]), 64'd66);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst frame_done", 64'(frame_done), 64'd0);
    chk("rst overrun", 64'(tick_overrun), 64'd0);

    // Pacman-only tick: ghosts skipped.
    pacman_dir = 4'b0001; ghost_dir = 16'h4444;
    frame(14, 0, 0, 4'b0000, fd1, nfd);
    chk("A fd cycle", 64'(fd1), 64'd3);
    chk("A fd count", 64'(nfd), 64'd1);
    chk("A pacman x", 64'(pos_x[10:0]), 64'd1382);
    chk("A blinky y", 64'(pos_y[19:10]), 64'd130);

    // All five sprites.
    frame(14, 0, 0, 4'b0000, fd1, nfd);
    chk("B fd cycle", 64'(fd1), 64'd11);
    chk("B sprite order", 64'({cyc_sprite[1], cyc_sprite[3], cyc_sprite[5], cyc_sprite[7], cyc_sprite[9]}),
        64'(15'b000_001_010_011_100));
    chk("B pacman x", 64'(pos_x[10:0]), 64'd1397);
    chk("B blinky x", 64'(pos_x[21:11]), 64'd1399);
    chk("B blinky y", 64'(pos_y[19:10]), 64'd145);

    // Direction snapshot: LEFT at acceptance, UP afterwards.
    pacman_dir = 4'b1000;
    frame(14, 0, 0, 4'b0010, fd1, nfd);
    chk("C fd cycle", 64'(fd1), 64'd3);
    chk("C dir cycle1", 64'(cyc_dir[1]), 64'b1000);
    chk("C dir cycle2", 64'(cyc_dir[2]), 64'b1000);
    chk("C pacman x", 64'(pos_x[10:0]), 64'd1382);
    chk("C pacman y", 64'(pos_y[9:0]), 64'd306);

    // Overrun during a full frame.
    pacman_dir = 4'b0001; ghost_dir = 16'h0000;
    frame(14, 4, 0, 4'b0000, fd1, nfd);
    chk("D overrun", 64'(tick_overrun), 64'd1);
    chk("D fd count", 64'(nfd), 64'd1);
    chk("D fd cycle", 64'(fd1), 64'd11);
    chk("D pacman x", 64'(pos_x[10:0]), 64'd1397);
    chk("D blinky y", 64'(pos_y[19:10]), 64'd145);
    chk("D clyde x", 64'(pos_x[54:44]), 64'd1415);

    // Dropped tick did not advance the ghost counter.
    frame(14, 0, 0, 4'b0000, fd1, nfd);
    chk("E fd cycle", 64'(fd1), 64'd3);
    chk("E overrun sticky", 64'(tick_overrun), 64'd1);
    chk("E pacman x", 64'(pos_x[10:0]), 64'd1412);

    // Reset in the middle of a full frame.
    ghost_dir = 16'h4444;
    frame(14, 0, 5, 4'b0000, fd1, nfd);
    chk("F fd count", 64'(nfd), 64'd0);
    chk("F pacman x after rst", 64'(cyc_px0[6]), 64'd1367);
    chk("F blinky y after rst", 64'(cyc_by[6]), 64'd130);
    chk("F busy after rst", 64'(cyc_busy[6]), 64'd0);
    chk("F overrun cleared", 64'(tick_overrun), 64'd0);

    frame(14, 0, 0, 4'b0000, fd1, nfd);
    chk("G fd cycle", 64'(fd1), 64'd3);
    chk("G pacman x", 64'(pos_x[10:0]), 64'd1382);

    // Random ticks, directions (including non-one-hot) and rare resets.
    for (int i = 0; i < 3000; i++) begin
      game_tick  = ($urandom_range(0, 7) == 0);
      pacman_dir = 4'($urandom);
      ghost_dir  = 16'($urandom);
      rst        = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    game_tick = 1'b0;
    rst       = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sprite_move_scheduler.md
Name: sprite_move_scheduler

Overview:
- Time-multiplexes the single shared position-update unit across the five sprites: PACMAN=0, BLINKY=1, PINKY=2, INKY=3, CLYDE=4.
- Owns the authoritative position registers for all sprites.
- On each game tick it snapshots the requested directions, then issues each sprite in fixed order to the update unit.
- It captures each returned position and pulses frame_done when all issued sprites are updated; the renderer and collision logic read the registered positions.

Parameters:
- UPD_LATENCY, 1: clock edges from the issue cycle to a valid upd_new_x/upd_new_y; range 1..7.
- GHOST_PERIOD, 2: ghosts move on every GHOST_PERIOD-th tick; Pacman moves every tick; range 1..15.
- PACMAN_RST_X/Y, 1367/306: Pacman reset position.
- BLINKY_RST_X/Y, 1399/130: Blinky reset position.
- PINKY_RST_X/Y, 439/434: Pinky reset position.
- INKY_RST_X/Y, 1031/402: Inky reset position.
- CLYDE_RST_X/Y, 1415/66: Clyde reset position.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- game_tick  in  1  one-cycle move request pulse
- pacman_dir  in  4  one-hot direction: RIGHT=0001, UP=0010, DOWN=0100, LEFT=1000
- ghost_dir  in  16  four ghost directions; [4k+3:4k] belongs to sprite k+1
- upd_cur_x  out  11  current x driven to the update unit
- upd_cur_y  out  10  current y driven to the update unit
- upd_dir  out  4  direction driven to the update unit
- upd_sprite  out  3  sprite index driven to the update unit
- upd_new_x  in  11  result x from the update unit
- upd_new_y  in  10  result y from the update unit
- pos_x  out  55  packed x positions; [11s+10:11s] belongs to sprite s
- pos_y  out  50  packed y positions; [10s+9:10s] belongs to sprite s
- busy  out  1  high while a frame is in progress
- frame_done  out  1  one-cycle pulse at frame completion
- tick_overrun  out  1  sticky flag: a tick arrived while busy

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - pos_x/pos_y load the *_RST parameters.
  - busy=0, frame_done=0, tick_overrun=0, upd_* outputs=0.
  - Ghost tick counter clears to 0; FSM enters IDLE.
  - Reset mid-frame aborts the frame: no partial capture survives, and no frame_done is generated.
- FSM states:
  - IDLE: game_tick=1 does the following:
    - snapshots pacman_dir and ghost_dir;
    - computes ghost_go = (ghost_cnt == GHOST_PERIOD-1);
    - updates ghost_cnt: wraps to 0 if ghost_go, otherwise increments;
    - sets slot=0 and moves to ISSUE.
  - ISSUE:
    - drives upd_sprite=slot, upd_cur_x/y=pos[slot], upd_dir=snapshot[slot];
    - loads wait counter=UPD_LATENCY and moves to WAIT.
  - WAIT:
    - holds the upd_* outputs stable;
    - decrements the counter; when the counter reaches 1, writes upd_new_x/y into pos[slot] at that edge.
    - Next state: if more slots remain, slot advances to the next issued sprite and the FSM goes to ISSUE; otherwise DONE.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- Slot skipping: when ghost_go=0, slots 1..4 are skipped entirely. They are not issued, and their positions are unchanged.
- Slot cost: each issued slot takes 1+UPD_LATENCY cycles.
  - Tick sampled at edge E0, all five sprites, UPD_LATENCY=1: frame_done is high in cycle 11 after E0.
  - Pacman only: frame_done is high in cycle 3.
- busy: high in every non-IDLE state.
- Ticks while busy:
  - game_tick while busy sets tick_overrun (cleared only by rst).
  - The tick is dropped and does not advance ghost_cnt.
  - A tick in the DONE cycle counts as busy.
- Direction snapshot: direction inputs are sampled only at tick acceptance. Changes during the frame have no effect on it.
- Passthrough: the scheduler does no validity, wrap-around or direction checking. A zero or non-one-hot direction is passed through unchanged.
- Register usage: pos_x/pos_y change only at capture edges or reset, and are registered (no combinational path from upd_new_*).
- Between frames the upd_* outputs hold their last values.

Decomposition:
- Shared package (pacman_pkg) holds:
  - sprite index constants PACMAN..CLYDE and NUM_SPRITES=5;
  - direction encodings RIGHT/LEFT/UP/DOWN;
  - X_W=11, Y_W=10;
  - reset coordinate constants, shared with the update unit.
- One natural sub-module: ghost_tick_divider (the counter plus ghost_go generation).
- The FSM, snapshot and position file stay in the top-level module.

Test Plan:
- Reset check: rst for 2 cycles -> pos_x slot0=1367, pos_y slot0=306, slot4=(1415,66); busy=0, frame_done=0, tick_overrun=0.
- Pacman RIGHT, all five sprites, GHOST_PERIOD=1:
  - Stimulus: pacman_dir=0001, ghost_dir=0, bench model returns x+15 on RIGHT (else hold) with 1-cycle latency, tick at E0.
  - Response: upd_sprite steps 0,1,2,3,4 every 2 cycles; frame_done in cycle 11; pacman=(1382,306); ghosts unchanged.
- Ghost period, GHOST_PERIOD=2, ghosts DOWN, two spaced ticks:
  - Tick 1 -> only slot 0 issued; frame_done in cycle 3.
  - Tick 2 -> all slots issued; blinky y=130->145.
- Overrun: second game_tick 4 cycles after the first -> tick_overrun=1 and stays 1; exactly one frame_done; pacman moved once.
- Direction snapshot: pacman_dir switched LEFT->UP at cycle 1 of the frame -> upd_dir=1000 for slot 0; pacman y unchanged.
- Reset mid-frame: rst at cycle 5 of a frame -> all positions at reset values next cycle; no frame_done; FSM IDLE; next tick runs normally.
